// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command/address front end: samples CA pins each clock and issues a registered
// one-hot command vector with bank select, CKE edge pulses, power state and the MR file.
module ddr4_cmd_decoder #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cke,
    input  logic                                   cs_n,
    input  logic                                   act_n,
    input  logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0] bg_in,
    input  logic [BAWIDTH-1:0]                     ba_in,
    input  logic [ADDRWIDTH-1:0]                   a_in,
    input  logic [2:0]                             mr_rsel,
    output logic [18:0]                            commands,
    output logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0] bg,
    output logic [BAWIDTH-1:0]                     ba,
    output logic [ADDRWIDTH-1:0]                   row,
    output logic [9:0]                             col,
    output logic [13:0]                            mr_rdata,
    output logic [1:0]                             pstate,
    output logic                                   cmd_err
);

    localparam int C_ACT  = 18;
    localparam int C_CFG  = 16;
    localparam int C_CKEH = 15;
    localparam int C_CKEL = 14;
    localparam int C_MRW  = 10;
    localparam int C_PD   = 9;
    localparam int C_PDX  = 8;
    localparam int C_PR   = 7;
    localparam int C_PRA  = 6;
    localparam int C_RD   = 5;
    localparam int C_RDA  = 4;
    localparam int C_REF  = 3;
    localparam int C_SRF  = 2;
    localparam int C_WR   = 1;
    localparam int C_WRA  = 0;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_PWRDN   = 2'd1,
        ST_SELFREF = 2'd2
    } pstate_t;

    pstate_t     state;
    logic        cke_q;
    logic [13:0] mr [0:7];

    logic [2:0]  ca;
    logic [2:0]  mr_idx;
    logic        bg0;
    logic [18:0] dec_cmd;
    logic        dec_err;
    logic        dec_hit;
    logic        dec_row_we;
    logic        dec_col_we;
    logic        dec_mr_we;
    logic        is_ref;
    logic        is_idle;
    logic        rise;
    logic        fall;
    logic        apply;
    logic        go_srf;
    logic        go_pd;
    logic        fall_err;
    logic [18:0] nxt_cmds;
    logic        nxt_err;

    assign pstate   = state;
    assign mr_rdata = mr[mr_rsel];
    assign bg0      = (BGWIDTH > 0) ? bg_in[0] : 1'b0;
    assign ca       = {a_in[16], a_in[15], a_in[14]};
    assign mr_idx   = {bg0, ba_in[1:0]};

    // Raw decode of the CA pins, independent of CKE and power state.
    always_comb begin
        dec_cmd    = '0;
        dec_err    = 1'b0;
        dec_hit    = 1'b0;
        dec_row_we = 1'b0;
        dec_col_we = 1'b0;
        dec_mr_we  = 1'b0;
        if (!act_n) begin
            dec_cmd[C_ACT] = 1'b1;
            dec_hit        = 1'b1;
            dec_row_we     = 1'b1;
        end else begin
            case (ca)
                3'b000: begin
                    dec_cmd[C_MRW] = 1'b1;
                    dec_hit        = 1'b1;
                    if (mr_idx == 3'd7) dec_err = 1'b1;
                    else                dec_mr_we = 1'b1;
                end
                3'b001: begin
                    dec_cmd[C_REF] = 1'b1;
                    dec_hit        = 1'b1;
                end
                3'b010: begin
                    if (a_in[10]) dec_cmd[C_PRA] = 1'b1;
                    else          dec_cmd[C_PR]  = 1'b1;
                    dec_hit = 1'b1;
                end
                3'b011: dec_err = 1'b1;
                3'b100: begin
                    if (a_in[10]) dec_cmd[C_WRA] = 1'b1;
                    else          dec_cmd[C_WR]  = 1'b1;
                    dec_hit    = 1'b1;
                    dec_col_we = 1'b1;
                end
                3'b101: begin
                    if (a_in[10]) dec_cmd[C_RDA] = 1'b1;
                    else          dec_cmd[C_RD]  = 1'b1;
                    dec_hit    = 1'b1;
                    dec_col_we = 1'b1;
                end
                3'b110: begin
                    dec_cmd[C_CFG] = 1'b1;
                    dec_hit        = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Gate the decode with CKE history and power state; a falling CKE carrying a
    // real command is still executed but flagged.
    always_comb begin
        is_ref   = act_n && (ca == 3'b001);
        is_idle  = cs_n || (act_n && (ca == 3'b111));
        rise     = !cke_q && cke;
        fall     = cke_q && !cke;
        apply    = 1'b0;
        go_srf   = 1'b0;
        go_pd    = 1'b0;
        fall_err = 1'b0;
        if (state == ST_ACTIVE && cke_q) begin
            if (cke)                  apply = !cs_n;
            else if (!cs_n && is_ref) go_srf = 1'b1;
            else if (is_idle)         go_pd = 1'b1;
            else begin
                apply    = 1'b1;
                fall_err = 1'b1;
            end
        end
        nxt_cmds         = apply ? dec_cmd : '0;
        nxt_cmds[C_CKEL] = fall;
        nxt_cmds[C_CKEH] = rise;
        nxt_cmds[C_SRF]  = go_srf;
        nxt_cmds[C_PD]   = go_pd;
        nxt_cmds[C_PDX]  = (state == ST_PWRDN) && rise;
        nxt_err          = (apply && dec_err) || fall_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_ACTIVE;
            cke_q    <= 1'b1;
            commands <= '0;
            cmd_err  <= 1'b0;
            bg       <= '0;
            ba       <= '0;
            row      <= '0;
            col      <= '0;
            for (int i = 0; i < 8; i++) mr[i] <= '0;
        end else begin
            commands <= nxt_cmds;
            cmd_err  <= nxt_err;
            cke_q    <= cke;
            if (apply && dec_hit) begin
                bg <= (BGWIDTH > 0) ? bg_in : '0;
                ba <= ba_in;
            end
            if (apply && dec_row_we) row <= a_in;
            if (apply && dec_col_we) col <= a_in[9:0];
            if (apply && dec_mr_we)  mr[mr_idx] <= a_in[13:0];
            case (state)
                ST_ACTIVE: begin
                    if (go_srf)     state <= ST_SELFREF;
                    else if (go_pd) state <= ST_PWRDN;
                end
                ST_PWRDN:   if (rise) state <= ST_ACTIVE;
                ST_SELFREF: if (rise) state <= ST_ACTIVE;
                default:    state <= ST_ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Bench for ddr4_cmd_decoder: command-name level reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_ddr4_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cke;
    logic        cs_n;
    logic        act_n;
    logic [1:0]  bg_in;
    logic [1:0]  ba_in;
    logic [16:0] a_in;
    logic [2:0]  mr_rsel;
    logic [18:0] commands;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [16:0] row;
    logic [9:0]  col;
    logic [13:0] mr_rdata;
    logic [1:0]  pstate;
    logic        cmd_err;

    int n_checks = 0;
    int n_fail   = 0;

    ddr4_cmd_decoder dut (
        .clk(clk), .reset(reset), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .bg_in(bg_in), .ba_in(ba_in), .a_in(a_in), .mr_rsel(mr_rsel),
        .commands(commands), .bg(bg), .ba(ba), .row(row), .col(col),
        .mr_rdata(mr_rdata), .pstate(pstate), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    string names [19] = '{"ACT", "BST", "CFG", "CKEH", "CKEL", "DPD", "DPDX", "MRR", "MRW",
                          "PD", "PDX", "PR", "PRA", "RD", "RDA", "REF", "SRF", "WR", "WRA"};

    logic [18:0] e_cmds;
    logic        e_err;
    logic [1:0]  e_bg, e_ba;
    logic [16:0] e_row;
    logic [9:0]  e_col;
    logic [13:0] e_mr [8];
    int          e_pst;
    logic        e_ckeq;
    bit          started = 0;

    function automatic logic [18:0] onehot(input string n);
        for (int i = 0; i < 19; i++)
            if (names[i] == n) return 19'(1) << (18 - i);
        return '0;
    endfunction

    function automatic string classify(input logic an, input logic [16:0] a);
        if (!an) return "ACT";
        case ({a[16], a[15], a[14]})
            3'd0: return "MRW";
            3'd1: return "REF";
            3'd2: return a[10] ? "PRA" : "PR";
            3'd3: return "RFU";
            3'd4: return a[10] ? "WRA" : "WR";
            3'd5: return a[10] ? "RDA" : "RD";
            3'd6: return "CFG";
            default: return "NOP";
        endcase
    endfunction

    task automatic issue(input string n);
        int idx;
        if (n == "NOP") return;
        if (n == "RFU") begin
            e_err = 1'b1;
            return;
        end
        e_cmds |= onehot(n);
        e_bg = bg_in;
        e_ba = ba_in;
        if (n == "ACT") e_row = a_in;
        if (n == "RD" || n == "RDA" || n == "WR" || n == "WRA") e_col = a_in[9:0];
        if (n == "MRW") begin
            idx = bg_in[0] * 4 + ba_in;
            if (idx == 7) e_err = 1'b1;
            else          e_mr[idx] = a_in[13:0];
        end
    endtask

    always @(posedge clk) begin
        string n;
        bit fall, rise;
        if (reset) begin
            started = 1;
            e_cmds = '0; e_err = 0; e_bg = 0; e_ba = 0; e_row = 0; e_col = 0;
            e_pst = 0; e_ckeq = 1;
            for (int i = 0; i < 8; i++) e_mr[i] = '0;
        end else if (started) begin
            e_cmds = '0;
            e_err  = 0;
            fall = e_ckeq && !cke;
            rise = !e_ckeq && cke;
            if (fall) e_cmds |= onehot("CKEL");
            if (rise) e_cmds |= onehot("CKEH");
            n = cs_n ? "DES" : classify(act_n, a_in);
            if (e_pst == 0) begin
                if (e_ckeq && cke) begin
                    if (n != "DES") issue(n);
                end else if (fall) begin
                    if (n == "REF") begin
                        e_cmds |= onehot("SRF");
                        e_pst = 2;
                    end else if (n == "DES" || n == "NOP") begin
                        e_cmds |= onehot("PD");
                        e_pst = 1;
                    end else begin
                        issue(n);
                        e_err = 1'b1;
                    end
                end
            end else if (rise) begin
                if (e_pst == 1) e_cmds |= onehot("PDX");
                e_pst = 0;
            end
            e_ckeq = cke;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_commands", 32'(commands), 32'(e_cmds));
            check("m_cmd_err",  32'(cmd_err),  32'(e_err));
            check("m_bg",       32'(bg),       32'(e_bg));
            check("m_ba",       32'(ba),       32'(e_ba));
            check("m_row",      32'(row),      32'(e_row));
            check("m_col",      32'(col),      32'(e_col));
            check("m_pstate",   32'(pstate),   32'(e_pst));
            check("m_mr_rdata", 32'(mr_rdata), 32'(e_mr[mr_rsel]));
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic k, input logic cs, input logic an,
                         input logic [1:0] g, input logic [1:0] b, input logic [16:0] a);
        cke = k; cs_n = cs; act_n = an; bg_in = g; ba_in = b; a_in = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic k);
        drive(k, 1'b1, 1'b1, 2'd0, 2'd0, 17'h1C000);
    endtask

    initial begin
        reset = 1'b1; mr_rsel = 3'd0;
        idle(1'b1);
        idle(1'b1);
        reset = 1'b0;
        idle(1'b1);
        check("reset_commands", 32'(commands), 32'h0);
        check("reset_pstate",   32'(pstate),   32'h0);
        check("reset_mr",       32'(mr_rdata), 32'h0);

        drive(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 17'h01234);
        check("act_cmd", 32'(commands), 32'h40000);
        check("act_bg",  32'(bg),       32'h1);
        check("act_ba",  32'(ba),       32'h1);
        check("act_row", 32'(row),      32'h1234);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 17'h14008);
        check("rd_cmd", 32'(commands), 32'h00020);
        check("rd_col", 32'(col),      32'h008);

        drive(1'b1, 1'b0, 1'b1, 2'd2, 2'd3, 17'h10400);
        check("wra_cmd", 32'(commands), 32'h00001);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 17'h08400);
        check("pra_cmd", 32'(commands), 32'h00040);
        check("pra_ba",  32'(ba),       32'h2);

        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 17'h00A5C);
        check("mrw_cmd", 32'(commands), 32'h00400);
        mr_rsel = 3'd1;
        idle(1'b1);
        check("mr1_read", 32'(mr_rdata), 32'h0A5C);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 17'h01111);
        check("mrw7_err", 32'(cmd_err),  32'h1);
        check("mrw7_keep", 32'(mr_rdata), 32'h0A5C);
        mr_rsel = 3'd7;
        idle(1'b1);
        check("mr7_read", 32'(mr_rdata), 32'h0);
        mr_rsel = 3'd1;

        drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 17'h04000);
        check("srf_cmd",    32'(commands), 32'h04004);
        check("srf_pstate", 32'(pstate),   32'h2);
        drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 17'h14008);
        check("sr_ignore", 32'(commands), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 17'h14008);
        check("srx_cmd",    32'(commands), 32'h08000);
        check("srx_pstate", 32'(pstate),   32'h0);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 17'h14008);
        check("post_srx_rd", 32'(commands), 32'h00020);

        idle(1'b0);
        check("pd_cmd",    32'(commands), 32'h04200);
        check("pd_pstate", 32'(pstate),   32'h1);
        idle(1'b1);
        check("pdx_cmd",    32'(commands), 32'h08100);
        check("pdx_pstate", 32'(pstate),   32'h0);

        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 17'h0C000);
        check("rfu_err", 32'(cmd_err),  32'h1);
        check("rfu_cmd", 32'(commands), 32'h0);

        drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 17'h14008);
        check("fall_rd_cmd", 32'(commands), 32'h04020);
        check("fall_rd_err", 32'(cmd_err),  32'h1);
        idle(1'b1);
        check("fall_rd_ckeh", 32'(commands), 32'h08000);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 17'h18000);
        check("cfg_cmd", 32'(commands), 32'h10000);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 17'h1C000);
        check("nop_cmd", 32'(commands), 32'h0);

        for (int i = 0; i < 60; i++) begin
            mr_rsel = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 17'($urandom_range(0, 17'h1FFFF)));
        end

        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        mr_rsel = 3'd1;
        reset = 1'b1;
        idle(1'b1);
        reset = 1'b0;
        check("rst_pstate", 32'(pstate),   32'h0);
        check("rst_mr",     32'(mr_rdata), 32'h0);
        check("rst_row",    32'(row),      32'h0);
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
